pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall, bubble and flush sequencer for an in-order pipeline.
//
// The pipeline register at index NUM_STAGES-1 is IF (upstream) and index 0
// is WB (downstream). The block freezes every register at and above the
// lowest stalled stage and inserts a bubble just below it. It also squashes
// wrong-path stages on a taken branch, deferring the squash while the lower
// pipe is frozen. A small FSM drains, flushes and refills the pipe when an
// exception commits at EXC_IDX.
//
// Optional feature: define macro STALL_PERF_EN to build a saturating 32-bit
// counter of cycles where IF is frozen. Without it, stall_cnt is tied to 0.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   stall_req    in   per-stage busy request (bit i = stage i)
//   ld_valid     in   producer slot j holds an in-flight load
//   ld_dest      in   producer slot j load destination (slot 0 in LSBs)
//   id_rs, id_rt in   decode source register specifiers
//   branch_taken in   redirect resolved below decode
//   exp_detect   in   exception detected at EXC_IDX
//   en           out  pipeline register advance enables
//   bubble       out  load a NOP into register i this cycle
//   redirect     out  one-cycle fetch redirect after an exception flush
//   state        out  FSM state (0 IDLE, 1 PEND, 2 FLUSH, 3 REFILL)
//   stall_cnt    out  IF-frozen cycle counter (STALL_PERF_EN only)
module pipe_stall_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int REG_W      = 5,
  parameter int LD_CHK     = 2,
  parameter int ID_IDX     = NUM_STAGES - 2,
  parameter int EXC_IDX    = 1,
  parameter int FLUSH_CYC  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_STAGES-1:0]     stall_req,
  input  logic [LD_CHK-1:0]         ld_valid,
  input  logic [LD_CHK*REG_W-1:0]   ld_dest,
  input  logic [REG_W-1:0]          id_rs,
  input  logic [REG_W-1:0]          id_rt,
  input  logic                      branch_taken,
  input  logic                      exp_detect,
  output logic [NUM_STAGES-1:0]     en,
  output logic [NUM_STAGES-1:0]     bubble,
  output logic                      redirect,
  output logic [1:0]                state,
  output logic [31:0]               stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_REFILL = 2'd3
  } state_t;

  localparam logic [NUM_STAGES-1:0] ZERO_V = {NUM_STAGES{1'b0}};
  localparam logic [NUM_STAGES-1:0] ONES_V = {NUM_STAGES{1'b1}};
  localparam logic [NUM_STAGES-1:0] ONE_V  = {{(NUM_STAGES-1){1'b0}}, 1'b1};
  // Stages 0..ID_IDX: a stall here blocks a branch squash.
  localparam logic [NUM_STAGES-1:0] LOW_MASK    = (ONE_V << (ID_IDX + 1)) - ONE_V;
  // Wrong-path stages on a taken branch: ID_IDX-1 and everything above.
  localparam logic [NUM_STAGES-1:0] BR_MASK     = ~((ONE_V << (ID_IDX - 1)) - ONE_V);
  // Stages below the exception point must drain before flushing.
  localparam logic [NUM_STAGES-1:0] EXC_LO_MASK = (ONE_V << EXC_IDX) - ONE_V;
  localparam logic [NUM_STAGES-1:0] EXC_HI_MASK = ~EXC_LO_MASK;
  localparam logic [3:0]            FLUSH_LAST  = 4'(FLUSH_CYC - 1);

  state_t                  state_r, state_nx_s;
  logic                    br_pend_r, br_pend_nx_s;
  logic [3:0]              flush_cnt_r, flush_cnt_nx_s;
  logic                    load_use_s;
  logic [NUM_STAGES-1:0]   eff_stall_s, low_bit_s, idle_en_s, idle_bub_s, br_bub_s;
  logic                    stall_low_s, exc_clr_s;
  logic [NUM_STAGES-1:0]   en_s, bubble_s;
  logic                    redirect_s;

  // Load-use hazard: a pending load writes a non-zero register that decode reads.
  always_comb begin
    load_use_s = 1'b0;
    for (int j = 0; j < LD_CHK; j++) begin
      if (ld_valid[j] && (ld_dest[j*REG_W +: REG_W] != {REG_W{1'b0}}) &&
          ((ld_dest[j*REG_W +: REG_W] == id_rs) || (ld_dest[j*REG_W +: REG_W] == id_rt))) begin
        load_use_s = 1'b1;
      end else begin
        load_use_s = load_use_s;
      end
    end
  end

  // Stall front, branch squash mask and drain condition.
  // low_bit_s isolates the lowest stalled stage s; subtracting one yields
  // the enables for every stage below s, and all ones when nothing stalls.
  always_comb begin
    eff_stall_s = stall_req | (load_use_s ? (ONE_V << ID_IDX) : ZERO_V);
    low_bit_s   = eff_stall_s & (~eff_stall_s + ONE_V);
    idle_en_s   = low_bit_s - ONE_V;
    idle_bub_s  = low_bit_s >> 1'b1;
    stall_low_s = |(eff_stall_s & LOW_MASK);
    exc_clr_s   = ~|(stall_req & EXC_LO_MASK);
    // Squash now if the lower pipe moves; frozen stages keep their content.
    if (!stall_low_s && (branch_taken || br_pend_r)) begin
      br_bub_s = BR_MASK & idle_en_s;
    end else begin
      br_bub_s = ZERO_V;
    end
  end

  // Next-state and output decode; reset forces a free-running pipe.
  always_comb begin
    state_nx_s     = state_r;
    br_pend_nx_s   = br_pend_r;
    flush_cnt_nx_s = flush_cnt_r;
    en_s           = ONES_V;
    bubble_s       = ZERO_V;
    redirect_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        en_s = idle_en_s;
        if (exp_detect) begin
          // Exception wins: a same-cycle branch is dropped.
          bubble_s       = idle_bub_s;
          flush_cnt_nx_s = 4'd0;
          state_nx_s     = exc_clr_s ? ST_FLUSH : ST_PEND;
        end else begin
          bubble_s     = idle_bub_s | br_bub_s;
          br_pend_nx_s = stall_low_s ? (br_pend_r | branch_taken) : 1'b0;
        end
      end
      ST_PEND: begin
        en_s = ZERO_V;
        if (exc_clr_s) begin
          flush_cnt_nx_s = 4'd0;
          state_nx_s     = ST_FLUSH;
        end else begin
          state_nx_s = ST_PEND;
        end
      end
      ST_FLUSH: begin
        en_s         = ONES_V;
        bubble_s     = EXC_HI_MASK;
        br_pend_nx_s = 1'b0;
        if (flush_cnt_r == FLUSH_LAST) begin
          flush_cnt_nx_s = 4'd0;
          state_nx_s     = ST_REFILL;
        end else begin
          flush_cnt_nx_s = flush_cnt_r + 4'd1;
        end
      end
      ST_REFILL: begin
        en_s         = idle_en_s;
        bubble_s     = idle_bub_s | br_bub_s;
        redirect_s   = 1'b1;
        br_pend_nx_s = stall_low_s ? (br_pend_r | branch_taken) : 1'b0;
        state_nx_s   = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    if (reset) begin
      en       = ONES_V;
      bubble   = ZERO_V;
      redirect = 1'b0;
    end else begin
      en       = en_s;
      bubble   = bubble_s;
      redirect = redirect_s;
    end
  end

  // State, pending-branch flag and flush hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      br_pend_r   <= 1'b0;
      flush_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_nx_s;
      br_pend_r   <= br_pend_nx_s;
      flush_cnt_r <= flush_cnt_nx_s;
    end
  end

  assign state = state_r;

`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles where IF cannot advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if (!en[NUM_STAGES-1] && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural model of the pipeline control rules.
module tb_pipe_stall_ctrl;
  localparam int N   = 5;
  localparam int RW  = 5;
  localparam int LC  = 2;
  localparam int ID  = 3;
  localparam int EXC = 1;
  localparam int FC  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    stall_req;
  logic [LC-1:0]   ld_valid;
  logic [LC*RW-1:0] ld_dest;
  logic [RW-1:0]   id_rs, id_rt;
  logic            branch_taken, exp_detect;
  logic [N-1:0]    en, bubble;
  logic            redirect;
  logic [1:0]      state;
  logic [31:0]     stall_cnt;

  int ncmp = 0;
  int nfail = 0;

  // Model state: draining for an exception, flush cycles left, refill cycle,
  // deferred branch, and the IF-frozen cycle count.
  bit      m_pend, m_refill, m_br;
  int      m_flush_left;
  longint  m_cnt;
  // Model outputs and derived conditions for the current cycle.
  logic [N-1:0] e_en, e_bub;
  logic         e_red;
  logic [1:0]   e_st;
  bit           m_lowstall, m_excclr;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .NUM_STAGES(N), .REG_W(RW), .LD_CHK(LC), .ID_IDX(ID), .EXC_IDX(EXC), .FLUSH_CYC(FC)
  ) dut (
    .clk(clk), .reset(reset), .stall_req(stall_req), .ld_valid(ld_valid),
    .ld_dest(ld_dest), .id_rs(id_rs), .id_rt(id_rt), .branch_taken(branch_taken),
    .exp_detect(exp_detect), .en(en), .bubble(bubble), .redirect(redirect),
    .state(state), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task model_eval();
    bit lu;
    int s;
    logic [N-1:0] eff;
    lu = 0;
    for (int j = 0; j < LC; j++) begin
      if (ld_valid[j] && ld_dest[j*RW +: RW] != 0 &&
          (ld_dest[j*RW +: RW] == id_rs || ld_dest[j*RW +: RW] == id_rt)) lu = 1;
    end
    eff = stall_req;
    if (lu) eff[ID] = 1'b1;
    s = N;
    for (int i = N - 1; i >= 0; i--) if (eff[i]) s = i;
    m_lowstall = (s <= ID);
    m_excclr = 1;
    for (int i = 0; i < EXC; i++) if (stall_req[i]) m_excclr = 0;

    if (m_flush_left > 0) e_st = 2'd2;
    else if (m_pend)      e_st = 2'd1;
    else if (m_refill)    e_st = 2'd3;
    else                  e_st = 2'd0;

    e_en = '1; e_bub = '0; e_red = 1'b0;
    if (reset) begin
      // free-running pipe while reset is held
    end else if (m_flush_left > 0) begin
      for (int i = EXC; i < N; i++) e_bub[i] = 1'b1;
    end else if (m_pend) begin
      e_en = '0;
    end else begin
      for (int i = 0; i < N; i++) e_en[i] = (i < s);
      if (s > 0 && s < N) e_bub[s-1] = 1'b1;
      e_red = m_refill;
      if ((m_refill || !exp_detect) && !m_lowstall && (branch_taken || m_br))
        for (int i = ID - 1; i < N; i++) if (e_en[i]) e_bub[i] = 1'b1;
    end
  endtask

  task model_update();
    bit was_refill;
    if (reset) begin
      m_pend = 0; m_refill = 0; m_br = 0; m_flush_left = 0; m_cnt = 0;
    end else begin
      if (!e_en[N-1] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_flush_left > 0) begin
        m_flush_left--;
        m_br = 0;
        if (m_flush_left == 0) m_refill = 1;
      end else if (m_pend) begin
        if (m_excclr) begin m_pend = 0; m_flush_left = FC; end
      end else begin
        was_refill = m_refill;
        m_refill = 0;
        if (!was_refill && exp_detect) begin
          if (m_excclr) m_flush_left = FC; else m_pend = 1;
        end else if (m_lowstall) begin
          m_br = m_br | branch_taken;
        end else begin
          m_br = 0;
        end
      end
    end
  endtask

  // One clock: compare against the model mid-cycle, then advance the model.
  task cyc();
    logic [31:0] exp_cnt;
    @(negedge clk);
    model_eval();
    chk("en", 32'(en), 32'(e_en));
    chk("bubble", 32'(bubble), 32'(e_bub));
    chk("redirect", 32'(redirect), 32'(e_red));
    chk("state", 32'(state), 32'(e_st));
`ifdef STALL_PERF_EN
    exp_cnt = m_cnt[31:0];
`else
    exp_cnt = 32'd0;
`endif
    chk("stall_cnt", stall_cnt, exp_cnt);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task idle_inputs();
    stall_req = '0; ld_valid = '0; ld_dest = '0; id_rs = '0; id_rt = '0;
    branch_taken = 1'b0; exp_detect = 1'b0;
  endtask

  initial begin
    logic [31:0] perf_exp;
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    m_pend = 0; m_refill = 0; m_br = 0; m_flush_left = 0; m_cnt = 0;

    // Reset state
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_en", 32'(en), 32'h1F);
    chk("rst_bubble", 32'(bubble), 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    cyc();
    reset = 1'b0;

    // Stall at stage 1
    stall_req = 5'b00010; #1;
    chk("stall1_en", 32'(en), 32'h01);
    chk("stall1_bub", 32'(bubble), 32'h01);
    cyc();

    // Load-use on id_rt
    stall_req = '0; ld_valid = 2'b01; ld_dest = {5'd0, 5'd8}; id_rt = 5'd8; id_rs = 5'd0; #1;
    chk("lu_en", 32'(en), 32'h07);
    chk("lu_bub", 32'(bubble), 32'h04);
    cyc();
    ld_dest = {5'd0, 5'd0}; id_rt = 5'd3; #1;
    chk("lu_r0_en", 32'(en), 32'h1F);
    cyc();
    ld_valid = '0;

    // Branch deferred behind a stall for 3 cycles
    stall_req = 5'b00010; branch_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1; chk("brst_en", 32'(en), 32'h01);
      cyc();
    end
    stall_req = '0; branch_taken = 1'b0; #1;
    chk("brpend_bub", 32'(bubble), 32'h1C);
    chk("brpend_en", 32'(en), 32'h1F);
    cyc();
    #1; chk("brdone_bub", 32'(bubble), 32'h00);
    cyc();
    branch_taken = 1'b1; #1;
    chk("br_now_bub", 32'(bubble), 32'h1C);
    cyc();
    stall_req = 5'b10000; #1;
    chk("br_if_en", 32'(en), 32'h0F);
    chk("br_if_bub", 32'(bubble), 32'h0C);
    cyc();
    idle_inputs();

    // Exception behind a stage-0 stall, FLUSH_CYC=2
    exp_detect = 1'b1; stall_req = 5'b00001; #1;
    chk("exc_s0", 32'(state), 32'd0);
    cyc();
    exp_detect = 1'b0; #1;
    chk("exc_s1", 32'(state), 32'd1);
    chk("pend_en", 32'(en), 32'h00);
    chk("pend_bub", 32'(bubble), 32'h00);
    cyc();
    stall_req = '0; #1;
    chk("exc_s2", 32'(state), 32'd1);
    cyc();
    #1; chk("exc_s3", 32'(state), 32'd2);
    chk("flush_bub", 32'(bubble), 32'h1E);
    chk("flush_en", 32'(en), 32'h1F);
    chk("flush_red", 32'(redirect), 32'h0);
    cyc();
    #1; chk("exc_s4", 32'(state), 32'd2);
    cyc();
    #1; chk("exc_s5", 32'(state), 32'd3);
    chk("refill_red", 32'(redirect), 32'h1);
    cyc();
    #1; chk("exc_s6", 32'(state), 32'd0);
    chk("idle_red", 32'(redirect), 32'h0);
    cyc();

    // Exception and branch together: branch discarded
    exp_detect = 1'b1; branch_taken = 1'b1; #1;
    chk("exbr_bub", 32'(bubble), 32'h00);
    cyc();
    idle_inputs();
    for (int k = 0; k < 4; k++) cyc();

    // Stall counter over 7 IF-frozen cycles
    reset = 1'b1; cyc(); reset = 1'b0;
    stall_req = 5'b10000;
    for (int k = 0; k < 7; k++) cyc();
    stall_req = '0; #1;
`ifdef STALL_PERF_EN
    perf_exp = 32'd7;
`else
    perf_exp = 32'd0;
`endif
    chk("perf_cnt", stall_cnt, perf_exp);
    cyc();

    // Reset in the middle of FLUSH
    exp_detect = 1'b1; cyc(); exp_detect = 1'b0;
    reset = 1'b1; #1;
    chk("rflush_st", 32'(state), 32'd2);
    chk("rflush_en", 32'(en), 32'h1F);
    chk("rflush_red", 32'(redirect), 32'h0);
    cyc();
    reset = 1'b0; #1;
    chk("rflush_idle", 32'(state), 32'd0);
    chk("rflush_red2", 32'(redirect), 32'h0);
    cyc();
    #1; chk("rflush_red3", 32'(redirect), 32'h0);
    cyc();

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(59, 0) == 0);
      for (int i = 0; i < N; i++) stall_req[i] = ($urandom_range(6, 0) == 0);
      for (int j = 0; j < LC; j++) begin
        ld_valid[j] = $urandom_range(1, 0);
        ld_dest[j*RW +: RW] = 5'($urandom_range(3, 0));
      end
      id_rs = 5'($urandom_range(3, 0));
      id_rt = 5'($urandom_range(3, 0));
      branch_taken = ($urandom_range(4, 0) == 0);
      exp_detect = ($urandom_range(9, 0) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
